mem_port_arbiter: RTL and testbench

- Shares the core's single-port synchronous instruction/data memory between two requesters: instruction fetch (IF, read-only) and load/store (D, read/write).
- Sits inside core_top between the fetch/LSU stages and the memory macro.
- Fixed priority to D, with a starvation guard for IF.
- One request in flight at a time; back-to-back issue is possible when the memory returns data in the same cycle the next request is accepted.

---
 rtl/mem_port_arbiter.sv | 107 ++++++++++
 tb/tb_mem_port_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single-port instruction/data memory between fetch (IF)
// and load/store (D): D has priority, and a streak guard keeps IF from starving.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STK_W = $clog2(STREAK_MAX + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LAT - 1);
  localparam logic [STK_W-1:0] STK_FULL = STK_W'(STREAK_MAX);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q;
  logic             owner_d_q;
  logic             we_q;
  logic [CNT_W-1:0] cnt_q;
  logic [STK_W-1:0] streak_q;
  logic [STK_W-1:0] streak_d;

  logic rsp_now, free, gnt_d, gnt_if, hs, rsp_ok;
  logic unused_addr_lo;

  // Grant and accept: a slot opens when idle or when the current access returns now.
  assign rsp_now = (state_q == BUSY) && (cnt_q == LAST_CNT);
  assign free    = (state_q == IDLE) || rsp_now;
  assign gnt_d   = d_req_valid && !(if_req_valid && (streak_q == STK_FULL));
  assign gnt_if  = if_req_valid && !gnt_d;

  assign if_req_ready = !rst && free && gnt_if;
  assign d_req_ready  = !rst && free && gnt_d;
  assign hs           = if_req_ready || d_req_ready;

  assign mem_en    = hs;
  assign mem_addr  = d_req_ready  ? d_addr[ADDR_W-1:2] :
                     if_req_ready ? if_addr[ADDR_W-1:2] : '0;
  assign mem_we    = (d_req_ready && d_we) ? d_wstrb : 4'b0000;
  assign mem_wdata = (d_req_ready && d_we) ? d_wdata : 32'h0;

  // Byte offsets are dropped; alignment is the requester's problem.
  assign unused_addr_lo = ^{if_addr[1:0], d_addr[1:0]};

  // Response: steered to the owner of the access in flight; stores ack with zero data.
  assign rsp_ok       = !rst && rsp_now;
  assign if_rsp_valid = rsp_ok && !owner_d_q;
  assign d_rsp_valid  = rsp_ok && owner_d_q;
  assign if_rsp_rdata = if_rsp_valid ? mem_rdata : 32'h0;
  assign d_rsp_rdata  = (d_rsp_valid && !we_q) ? mem_rdata : 32'h0;

  always_comb begin
    streak_d = streak_q;
    if (d_req_ready) begin
      if (!if_req_valid)              streak_d = '0;
      else if (streak_q != STK_FULL)  streak_d = streak_q + STK_W'(1);
    end else if (if_req_ready) begin
      streak_d = '0;
    end
  end

  // State update
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      streak_q  <= '0;
    end else begin
      streak_q <= streak_d;
      if (hs) begin
        state_q   <= BUSY;
        owner_d_q <= d_req_ready;
        we_q      <= d_req_ready && d_we;
        cnt_q     <= '0;
      end else if (rsp_now) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=1 and a MEM_LAT=3 instance, each with its own memory model.
module tb_mem_port_arbiter;

  localparam bit Y = 1'b1;
  localparam bit N = 1'b0;
  localparam int SMAX = 4;

  logic clk;
  logic mem_init;
  logic        rst_s [2];
  logic        if_v  [2];
  logic [31:0] if_a  [2];
  logic        d_v   [2];
  logic        d_we  [2];
  logic [31:0] d_a   [2];
  logic [31:0] d_wd  [2];
  logic [3:0]  d_st  [2];
  logic        if_rdy[2];
  logic        d_rdy [2];
  logic        if_rv [2];
  logic [31:0] if_rd [2];
  logic        d_rv  [2];
  logic [31:0] d_rd  [2];
  logic        men   [2];
  logic [3:0]  mwe   [2];
  logic [29:0] maddr [2];
  logic [31:0] mwd   [2];
  logic [31:0] mrd   [2];

  int checks;
  int errors;

  mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(1), .STREAK_MAX(SMAX)) u_lat1 (
    .clk(clk), .rst(rst_s[0]),
    .if_req_valid(if_v[0]), .if_req_ready(if_rdy[0]), .if_addr(if_a[0]),
    .if_rsp_valid(if_rv[0]), .if_rsp_rdata(if_rd[0]),
    .d_req_valid(d_v[0]), .d_req_ready(d_rdy[0]), .d_addr(d_a[0]), .d_we(d_we[0]),
    .d_wdata(d_wd[0]), .d_wstrb(d_st[0]), .d_rsp_valid(d_rv[0]), .d_rsp_rdata(d_rd[0]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(3), .STREAK_MAX(SMAX)) u_lat3 (
    .clk(clk), .rst(rst_s[1]),
    .if_req_valid(if_v[1]), .if_req_ready(if_rdy[1]), .if_addr(if_a[1]),
    .if_rsp_valid(if_rv[1]), .if_rsp_rdata(if_rd[1]),
    .d_req_valid(d_v[1]), .d_req_ready(d_rdy[1]), .d_addr(d_a[1]), .d_we(d_we[1]),
    .d_wdata(d_wd[1]), .d_wstrb(d_st[1]), .d_rsp_valid(d_rv[1]), .d_rsp_rdata(d_rd[1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEAD_BEEF;
    if (i == 8) return 32'h0000_0000;
    return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  // Memory models: one read-latency register for the LAT=1 port, a 3-deep pipe for LAT=3.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] rd_a;
  logic [31:0] pipe_b [3];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
      rd_a <= 32'hBAD0_BAD0;
    end else if (men[0]) begin
      rd_a <= mem_a[maddr[0][7:0]];
      for (int b = 0; b < 4; b++)
        if (mwe[0][b]) mem_a[maddr[0][7:0]][8*b +: 8] <= mwd[0][8*b +: 8];
    end else begin
      rd_a <= 32'hBAD0_BAD0;
    end
  end

  always @(posedge clk) begin
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (mem_init) begin
      for (int j = 0; j < 256; j++) mem_b[j] <= init_word(j);
      pipe_b[0] <= 32'hBAD1_BAD1;
    end else if (men[1]) begin
      pipe_b[0] <= mem_b[maddr[1][7:0]];
      for (int c = 0; c < 4; c++)
        if (mwe[1][c]) mem_b[maddr[1][7:0]][8*c +: 8] <= mwd[1][8*c +: 8];
    end else begin
      pipe_b[0] <= 32'hBAD1_BAD1;
    end
  end

  assign mrd[0] = rd_a;
  assign mrd[1] = pipe_b[2];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(int k, string tag, bit eir, bit edr, bit een, logic [3:0] ewe,
                         logic [29:0] ea, logic [31:0] ewd, bit eirv, logic [31:0] eird,
                         bit edrv, logic [31:0] edrd);
    chk($sformatf("%s/u%0d if_req_ready", tag, k), 32'(if_rdy[k]), 32'(eir));
    chk($sformatf("%s/u%0d d_req_ready", tag, k), 32'(d_rdy[k]), 32'(edr));
    chk($sformatf("%s/u%0d mem_en", tag, k), 32'(men[k]), 32'(een));
    chk($sformatf("%s/u%0d mem_we", tag, k), 32'(mwe[k]), 32'(ewe));
    chk($sformatf("%s/u%0d mem_addr", tag, k), 32'(maddr[k]), 32'(ea));
    chk($sformatf("%s/u%0d mem_wdata", tag, k), mwd[k], ewd);
    chk($sformatf("%s/u%0d if_rsp_valid", tag, k), 32'(if_rv[k]), 32'(eirv));
    chk($sformatf("%s/u%0d if_rsp_rdata", tag, k), if_rd[k], eird);
    chk($sformatf("%s/u%0d d_rsp_valid", tag, k), 32'(d_rv[k]), 32'(edrv));
    chk($sformatf("%s/u%0d d_rsp_rdata", tag, k), d_rd[k], edrd);
  endtask

  task automatic drv(int k, bit r, bit iv, logic [31:0] ia, bit dv, bit dw,
                     logic [31:0] da, logic [31:0] wd, logic [3:0] st);
    rst_s[k] = r; if_v[k] = iv; if_a[k] = ia; d_v[k] = dv; d_we[k] = dw;
    d_a[k] = da; d_wd[k] = wd; d_st[k] = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r; bit iv; logic [31:0] ia; bit dv; bit dw; logic [31:0] da; logic [31:0] wd; logic [3:0] st;
    bit eir; bit edr; bit een; logic [3:0] ewe; logic [29:0] ea; logic [31:0] ewd;
    bit eirv; logic [31:0] eird; bit edrv; logic [31:0] edrd;
  } vec_t;

  function automatic vec_t mkv(bit r, bit iv, logic [31:0] ia, bit dv, bit dw, logic [31:0] da,
                               logic [31:0] wd, logic [3:0] st, bit eir, bit edr, bit een,
                               logic [3:0] ewe, logic [29:0] ea, logic [31:0] ewd, bit eirv,
                               logic [31:0] eird, bit edrv, logic [31:0] edrd);
    vec_t v;
    v.r = r; v.iv = iv; v.ia = ia; v.dv = dv; v.dw = dw; v.da = da; v.wd = wd; v.st = st;
    v.eir = eir; v.edr = edr; v.een = een; v.ewe = ewe; v.ea = ea; v.ewd = ewd;
    v.eirv = eirv; v.eird = eird; v.edrv = edrv; v.edrd = edrd;
    return v;
  endfunction

  vec_t vq[$];

  task automatic run_vecs(int k, string tag);
    foreach (vq[i]) begin
      tick();
      drv(k, vq[i].r, vq[i].iv, vq[i].ia, vq[i].dv, vq[i].dw, vq[i].da, vq[i].wd, vq[i].st);
      #4;
      chk_all(k, $sformatf("%s[%0d]", tag, i), vq[i].eir, vq[i].edr, vq[i].een, vq[i].ewe,
              vq[i].ea, vq[i].ewd, vq[i].eirv, vq[i].eird, vq[i].edrv, vq[i].edrd);
    end
    vq.delete();
  endtask

  // Reference model: each accepted access is remembered with the cycle its response is due.
  int          cyc;
  int          lat [2];
  bit          pend_v [2];
  int          pend_due [2];
  bit          pend_d [2];
  logic [31:0] pend_data [2];
  int          streak_m [2];
  logic [31:0] ref_mem [2][256];

  task automatic model_reset_all();
    for (int k = 0; k < 2; k++) begin
      pend_v[k] = 0; streak_m[k] = 0;
      for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(i);
    end
  endtask

  task automatic model_step(int k);
    bit resp_now, free, gi, gd;
    int w;
    logic [29:0] ea;
    logic [3:0] ewe;
    logic [31:0] ewd;
    if (rst_s[k]) begin
      chk_all(k, "rnd_rst", N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, N, 32'h0);
      pend_v[k] = 0;
      streak_m[k] = 0;
      return;
    end
    resp_now = pend_v[k] && (pend_due[k] == cyc);
    free = !pend_v[k] || resp_now;
    gi = 0; gd = 0;
    if (free) begin
      if (if_v[k] && d_v[k]) begin
        if (streak_m[k] == SMAX) gi = 1; else gd = 1;
      end else begin
        gi = if_v[k]; gd = d_v[k];
      end
    end
    ea  = gd ? d_a[k][31:2] : (gi ? if_a[k][31:2] : 30'h0);
    ewe = (gd && d_we[k]) ? d_st[k] : 4'h0;
    ewd = (gd && d_we[k]) ? d_wd[k] : 32'h0;
    chk_all(k, $sformatf("rnd@%0d", cyc), gi, gd, gi | gd, ewe, ea, ewd,
            resp_now && !pend_d[k], (resp_now && !pend_d[k]) ? pend_data[k] : 32'h0,
            resp_now && pend_d[k], (resp_now && pend_d[k]) ? pend_data[k] : 32'h0);
    if (resp_now) pend_v[k] = 0;
    if (gi || gd) begin
      w = int'(ea[7:0]);
      pend_v[k] = 1;
      pend_due[k] = cyc + lat[k];
      pend_d[k] = gd;
      pend_data[k] = (gd && d_we[k]) ? 32'h0 : ref_mem[k][w];
      for (int b = 0; b < 4; b++)
        if (ewe[b]) ref_mem[k][w][8*b +: 8] = ewd[8*b +: 8];
      if (gd && if_v[k]) streak_m[k] = (streak_m[k] < SMAX) ? streak_m[k] + 1 : SMAX;
      else streak_m[k] = 0;
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    lat[0] = 1; lat[1] = 3;
    mem_init = 1'b1;
    for (int k = 0; k < 2; k++) drv(k, Y, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);

    // MEM_LAT=1 directed table: reset, IF read, store, reload, pipelined IF->D, D priority.
    tick(); mem_init = 1'b0; drv(1, N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);
    #4;
    chk_all(0, "reset_hold", N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, N, 32'h0);
    vq.push_back(mkv(Y, Y, 32'h10, Y, N, 32'h20, 32'h0, 4'h0,         N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(N, Y, 32'h10, N, N, 32'h0, 32'h0, 4'h0,          Y, N, Y, 4'h0, 30'h4, 32'h0, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0,           N, N, N, 4'h0, 30'h0, 32'h0, Y, 32'hDEAD_BEEF, N, 32'h0));
    vq.push_back(mkv(N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0,           N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(N, N, 32'h0, Y, Y, 32'h20, 32'h1122_3344, 4'b0011, N, Y, Y, 4'b0011, 30'h8, 32'h1122_3344, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0,           N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, Y, 32'h0));
    vq.push_back(mkv(N, N, 32'h0, Y, N, 32'h23, 32'hFFFF_FFFF, 4'hF,  N, Y, Y, 4'h0, 30'h8, 32'h0, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0,           N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, Y, 32'h0000_3344));
    vq.push_back(mkv(N, Y, 32'h10, N, N, 32'h0, 32'h0, 4'h0,          Y, N, Y, 4'h0, 30'h4, 32'h0, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(N, N, 32'h0, Y, N, 32'h20, 32'h0, 4'h0,          N, Y, Y, 4'h0, 30'h8, 32'h0, Y, 32'hDEAD_BEEF, N, 32'h0));
    vq.push_back(mkv(N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0,           N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, Y, 32'h0000_3344));
    vq.push_back(mkv(N, Y, 32'h10, Y, N, 32'h20, 32'h0, 4'h0,         N, Y, Y, 4'h0, 30'h8, 32'h0, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(N, Y, 32'h10, N, N, 32'h0, 32'h0, 4'h0,          Y, N, Y, 4'h0, 30'h4, 32'h0, N, 32'h0, Y, 32'h0000_3344));
    vq.push_back(mkv(N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0,           N, N, N, 4'h0, 30'h0, 32'h0, Y, 32'hDEAD_BEEF, N, 32'h0));
    run_vecs(0, "tbl_lat1");

    // Contention on LAT=1: build a streak, reset it, then expect D,D,D,D,IF repeating.
    for (int c = 0; c < 13; c++) begin
      bit exp_if, exp_d;
      tick();
      drv(0, c == 2, Y, 32'h10, Y, N, 32'h20, 32'h0, 4'h0);
      #4;
      if (c < 2)       begin exp_if = 0; exp_d = 1; end
      else if (c == 2) begin exp_if = 0; exp_d = 0; end
      else             begin exp_if = ((c - 3) % 5 == 4); exp_d = !exp_if; end
      chk($sformatf("contend[%0d] if_ready", c), 32'(if_rdy[0]), 32'(exp_if));
      chk($sformatf("contend[%0d] d_ready", c), 32'(d_rdy[0]), 32'(exp_d));
      chk($sformatf("contend[%0d] both_ready", c), 32'(if_rdy[0] & d_rdy[0]), 32'h0);
    end
    tick(); drv(0, Y, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);

    // LAT=3 back-to-back IF with valid held high.
    tick(); drv(1, Y, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);
    for (int c = 0; c < 13; c++) begin
      bit er, ev;
      tick();
      drv(1, N, c <= 9, 32'h10, N, N, 32'h0, 32'h0, 4'h0);
      #4;
      er = (c <= 9) && (c % 3 == 0);
      ev = (c > 0) && (c % 3 == 0);
      chk($sformatf("b2b[%0d] if_ready", c), 32'(if_rdy[1]), 32'(er));
      chk($sformatf("b2b[%0d] mem_en", c), 32'(men[1]), 32'(er));
      chk($sformatf("b2b[%0d] if_rsp_valid", c), 32'(if_rv[1]), 32'(ev));
      chk($sformatf("b2b[%0d] if_rsp_rdata", c), if_rd[1], ev ? 32'hDEAD_BEEF : 32'h0);
    end

    // LAT=3 reset one cycle after a load is accepted: the load must never answer.
    vq.push_back(mkv(N, N, 32'h0, Y, N, 32'h20, 32'h0, 4'h0,  N, Y, Y, 4'h0, 30'h8, 32'h0, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(Y, Y, 32'h10, Y, Y, 32'h24, 32'h1, 4'hF, N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, N, 32'h0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mkv(N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0, N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(N, Y, 32'h10, N, N, 32'h0, 32'h0, 4'h0,  Y, N, Y, 4'h0, 30'h4, 32'h0, N, 32'h0, N, 32'h0));
    for (int i = 0; i < 2; i++)
      vq.push_back(mkv(N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0, N, N, N, 4'h0, 30'h0, 32'h0, N, 32'h0, N, 32'h0));
    vq.push_back(mkv(N, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0,   N, N, N, 4'h0, 30'h0, 32'h0, Y, 32'hDEAD_BEEF, N, 32'h0));
    run_vecs(1, "rst_mid_lat3");

    // Randomized traffic on both instances against the reference model.
    tick();
    mem_init = 1'b1;
    for (int k = 0; k < 2; k++) drv(k, Y, N, 32'h0, N, N, 32'h0, 32'h0, 4'h0);
    model_reset_all();
    cyc = 0;
    for (int n = 0; n < 3000; n++) begin
      tick();
      mem_init = 1'b0;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        rst_s[k] = ($urandom_range(0, 99) == 0);
        if_v[k]  = ($urandom_range(0, 2) != 0);
        if_a[k]  = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        d_v[k]   = ($urandom_range(0, 2) != 0);
        d_we[k]  = ($urandom_range(0, 1) == 1);
        d_a[k]   = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        d_wd[k]  = $urandom;
        d_st[k]  = 4'($urandom_range(0, 15));
      end
      #4;
      model_step(0);
      model_step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
